// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one load/store at a time from the pipeline and drives a
// valid/ready memory port. It formats the load data, builds the store byte lanes and aborts on timeout.
module dmem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  st_size,
    input  logic [2:0]  ld_size,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        done,
    output logic        misaligned,
    output logic        bus_error,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [2:0]  ld_size_q;
    logic [3:0]  mem_we_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept, abort, half_op, word_op, timeout_hit;
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata, load_fmt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign half_op = req_we ? (st_size == 2'b01) : (ld_size[1:0] == 2'b01);
    assign word_op = req_we ? st_size[1] : ld_size[1];
    assign misaligned = (state_q == IDLE) && req_valid &&
                        ((half_op && req_addr[0]) || (word_op && (req_addr[1:0] != 2'b00)));
    assign timeout_hit = (cnt_q == TO_LAST);

    // Memory port: mem_req_valid stays high with stable fields until mem_req_ready is sampled high on a
    // rising edge. That edge transfers the request. mem_resp_valid counts only while the controller is in RESP.
    assign mem_req_valid = (state_q == REQ);
    assign mem_addr      = addr_q[31:2];
    assign mem_we        = mem_we_q;
    assign mem_wdata     = mem_wdata_q;

    assign stall       = ((state_q == IDLE) && req_valid && !misaligned) ||
                         (state_q == REQ) || (state_q == RESP);
    assign done        = (state_q == DONE);
    assign rdata_valid = (state_q == DONE) && !we_q && !err_q;
    assign bus_error   = (state_q == DONE) && err_q;
    assign rdata       = rdata_q;
    assign state_dbg   = state_q;

    always_comb begin
        lane_we    = 4'b1111;
        lane_wdata = req_wdata;
        case (st_size)
            2'b00: begin
                lane_we    = 4'b0001 << req_addr[1:0];
                lane_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                lane_we    = 4'b0011 << {req_addr[1], 1'b0};
                lane_wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte  = mem_resp_data[8*addr_q[1:0] +: 8];
        ld_half  = addr_q[1] ? mem_resp_data[31:16] : mem_resp_data[15:0];
        load_fmt = mem_resp_data;
        case (ld_size_q)
            3'b000:  load_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_fmt = {24'h0, ld_byte};
            3'b101:  load_fmt = {16'h0, ld_half};
            default: load_fmt = mem_resp_data;
        endcase
    end

    // A completion in the last permitted cycle takes precedence over the timeout.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !misaligned) begin
                    state_d = REQ;
                    accept  = 1'b1;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = we_q ? DONE : RESP;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 16'h0;
            addr_q      <= 32'h0;
            we_q        <= 1'b0;
            ld_size_q   <= 3'b0;
            mem_we_q    <= 4'b0;
            mem_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q      <= req_addr;
                we_q        <= req_we;
                ld_size_q   <= ld_size;
                mem_we_q    <= req_we ? lane_we : 4'b0000;
                mem_wdata_q <= req_we ? lane_wdata : 32'h0;
                cnt_q       <= 16'h0;
                err_q       <= 1'b0;
            end else if ((state_q == REQ) || (state_q == RESP)) begin
                cnt_q <= cnt_q + 16'h1;
            end
            if (abort) begin
                err_q <= 1'b1;
            end
            if ((state_q == RESP) && mem_resp_valid) begin
                rdata_q <= load_fmt;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: it drives directed load/store vectors and checks them through expected queues.
// A second instance with a short timeout exercises the abort path.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_valid_t = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [1:0]  st_size = 2'b0;
    logic [2:0]  ld_size = 3'b0;
    logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0, tie0 = 1'b0;
    logic [31:0] mem_resp_data = 32'h0;

    logic        stall, rdata_valid, done, misaligned, bus_error, mem_req_valid;
    logic [31:0] rdata, mem_wdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_we;
    logic [1:0]  state_dbg;

    logic        stall_t, rdata_valid_t, done_t, misaligned_t, bus_error_t, mem_req_valid_t;
    logic [31:0] rdata_t, mem_wdata_t;
    logic [29:0] mem_addr_t;
    logic [3:0]  mem_we_t;
    logic [1:0]  state_dbg_t;

    int n_checks = 0;
    int n_errors = 0;

    logic [65:0] exp_mem_q[$];
    logic [33:0] exp_done_q[$];
    logic [33:0] exp_to_q[$];

    dmem_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .st_size(st_size), .ld_size(ld_size), .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .done(done), .misaligned(misaligned), .bus_error(bus_error),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .state_dbg(state_dbg)
    );

    dmem_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset(reset), .req_valid(req_valid_t), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .st_size(st_size), .ld_size(ld_size), .stall(stall_t), .rdata(rdata_t),
        .rdata_valid(rdata_valid_t), .done(done_t), .misaligned(misaligned_t), .bus_error(bus_error_t),
        .mem_req_valid(mem_req_valid_t), .mem_req_ready(tie0), .mem_addr(mem_addr_t),
        .mem_we(mem_we_t), .mem_wdata(mem_wdata_t), .mem_resp_valid(tie0),
        .mem_resp_data(mem_resp_data), .state_dbg(state_dbg_t)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // memory-side monitor
    always @(negedge clk) begin
        if (!reset && mem_req_valid && mem_req_ready) begin
            if (exp_mem_q.size() == 0) check("mem_unexpected", 66'h1, 66'h0);
            else check("mem_fields", {mem_addr, mem_we, mem_wdata}, exp_mem_q.pop_front());
        end
    end

    // completion monitors
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_done_q.size() == 0) check("done_unexpected", 66'h1, 66'h0);
            else check("done_result", {bus_error, rdata_valid, rdata_valid ? rdata : 32'h0},
                       exp_done_q.pop_front());
        end
        if (!reset && done_t) begin
            if (exp_to_q.size() == 0) check("to_unexpected", 66'h1, 66'h0);
            else check("to_result", {bus_error_t, rdata_valid_t, rdata_valid_t ? rdata_t : 32'h0},
                       exp_to_q.pop_front());
        end
    end

    // driver: one transaction with programmable ready/response delays
    task automatic run_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] st, input logic [2:0] ld, input int rdly, input int sdly,
                          input logic [31:0] resp, input logic early, input logic [3:0] exp_we,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd, input logic abort);
        int gaps;
        logic [65:0] exp_m;
        gaps  = 0;
        exp_m = {addr[31:2], exp_we, exp_wd};
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; st_size = st; ld_size = ld;
        @(negedge clk);
        check("accept_stall", {misaligned, stall}, 66'b01);
        exp_mem_q.push_back(exp_m);
        if (!abort) exp_done_q.push_back({1'b0, ~we, we ? 32'h0 : exp_rd});
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        st_size = 2'($urandom_range(0, 3)); ld_size = 3'($urandom_range(0, 7));
        repeat (rdly) begin
            @(negedge clk);
            if (!stall || !mem_req_valid || ({mem_addr, mem_we, mem_wdata} != exp_m)) gaps++;
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b1;
        if (early) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = ~resp;
        end
        @(posedge clk); #1;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        if (!we) begin
            repeat (sdly) begin
                @(negedge clk);
                if (!stall || mem_req_valid) gaps++;
                @(posedge clk); #1;
            end
            if (abort) begin
                check("abort_wait_stable", 66'(gaps), 66'h0);
                reset = 1'b1;
                #1;
                check("reset_mid_resp", {mem_req_valid, stall, done, rdata_valid, state_dbg}, 66'h0);
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = resp;
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
        end
        @(negedge clk);
        check("done_timing", {done, stall, mem_req_valid}, 66'b100);
        check("wait_stable", 66'(gaps), 66'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_pulse", {done, rdata_valid, bus_error}, 66'h0);
        @(posedge clk); #1;
    endtask

    task automatic check_misaligned(input logic we, input logic [31:0] addr, input logic [1:0] st,
                                    input logic [2:0] ld, input logic exp_mis);
        req_valid = 1'b1; req_we = we; req_addr = addr; st_size = st; ld_size = ld;
        @(negedge clk);
        check("misaligned_flag", {misaligned, stall, mem_req_valid}, {63'h0, exp_mis, ~exp_mis, 1'b0});
        if (exp_mis) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("misaligned_idle", {mem_req_valid, stall, done, state_dbg}, 66'h0);
        end
        req_valid = 1'b0;
        if (!exp_mis) begin
            @(posedge clk); #1;
            reset = 1'b1;
            #1;
            reset = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int found;
        int gaps_t;
        #3;
        check("reset_outputs", {stall, done, rdata_valid, bus_error, misaligned, mem_req_valid, mem_we,
                                state_dbg}, 66'h0);
        check("reset_rdata", {rdata, mem_wdata}, 66'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // stores: SB, SH, SW (size 11)
        run_op(1'b1, 32'h0000_1003, 32'h0000_00AB, 2'b00, 3'b0, 0, 0, 32'h0, 1'b0,
               4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0);
        run_op(1'b1, 32'h0000_0102, 32'h1234_5678, 2'b01, 3'b0, 1, 0, 32'h0, 1'b0,
               4'b1100, 32'h5678_5678, 32'h0, 1'b0);
        run_op(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b11, 3'b0, 0, 0, 32'h0, 1'b0,
               4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
        // loads: LH/LHU upper half, LB/LBU lanes, LH lower half positive
        run_op(1'b0, 32'h0000_2002, 32'h0, 2'b00, 3'b001, 0, 0, 32'h8001_1234, 1'b0,
               4'b0000, 32'h0, 32'hFFFF_8001, 1'b0);
        run_op(1'b0, 32'h0000_2002, 32'h0, 2'b00, 3'b101, 0, 0, 32'h8001_1234, 1'b0,
               4'b0000, 32'h0, 32'h0000_8001, 1'b0);
        run_op(1'b0, 32'h0000_0001, 32'h0, 2'b00, 3'b000, 0, 1, 32'h0000_8000, 1'b0,
               4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0);
        run_op(1'b0, 32'h0000_0003, 32'h0, 2'b00, 3'b100, 0, 0, 32'hF000_0000, 1'b0,
               4'b0000, 32'h0, 32'h0000_00F0, 1'b0);
        run_op(1'b0, 32'h0000_0000, 32'h0, 2'b00, 3'b001, 0, 0, 32'h0000_7FFF, 1'b0,
               4'b0000, 32'h0, 32'h0000_7FFF, 1'b0);
        // delayed ready and response; reserved load size treated as LW
        run_op(1'b0, 32'h0000_0008, 32'h0, 2'b00, 3'b010, 3, 2, 32'h1234_5678, 1'b0,
               4'b0000, 32'h0, 32'h1234_5678, 1'b0);
        run_op(1'b0, 32'h0000_000C, 32'h0, 2'b00, 3'b111, 0, 0, 32'hCAFE_F00D, 1'b0,
               4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0);
        // response presented together with ready must be ignored
        run_op(1'b0, 32'h0000_0014, 32'h0, 2'b00, 3'b010, 0, 1, 32'h0BAD_CAFE, 1'b1,
               4'b0000, 32'h0, 32'h0BAD_CAFE, 1'b0);

        // misalignment: rejected cases plus an aligned half store at the edge
        check_misaligned(1'b0, 32'h0000_0006, 2'b00, 3'b010, 1'b1);
        check_misaligned(1'b1, 32'h0000_0001, 2'b01, 3'b000, 1'b1);
        check_misaligned(1'b1, 32'h0000_0002, 2'b10, 3'b000, 1'b1);
        check_misaligned(1'b0, 32'h0000_0003, 2'b00, 3'b101, 1'b1);
        check_misaligned(1'b0, 32'h0000_000E, 2'b00, 3'b111, 1'b1);
        check_misaligned(1'b1, 32'h0000_0006, 2'b01, 3'b000, 1'b0);

        // reset during RESP, then a normal LW
        run_op(1'b0, 32'h0000_0010, 32'h0, 2'b00, 3'b010, 0, 1, 32'h1111_2222, 1'b0,
               4'b0000, 32'h0, 32'h0, 1'b1);
        run_op(1'b0, 32'h0000_0020, 32'h0, 2'b00, 3'b010, 1, 0, 32'hA5A5_A5A5, 1'b0,
               4'b0000, 32'h0, 32'hA5A5_A5A5, 1'b0);

        // timeout abort on the short-timeout instance (ready never given)
        req_we = 1'b0; req_addr = 32'h0000_0040; ld_size = 3'b010; req_valid_t = 1'b1;
        exp_to_q.push_back({1'b1, 1'b0, 32'h0});
        @(posedge clk); #1;
        req_valid_t = 1'b0;
        found  = 0;
        gaps_t = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done_t) begin
                found = i;
                break;
            end
            if (!stall_t || !mem_req_valid_t) gaps_t++;
        end
        check("timeout_latency", 66'(found), 66'd5);
        check("timeout_done", {bus_error_t, rdata_valid_t, stall_t, mem_req_valid_t}, 66'b1000);
        check("timeout_wait", 66'(gaps_t), 66'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("timeout_pulse", {bus_error_t, done_t, stall_t, state_dbg_t}, 66'h0);
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        check("queues_drained", {32'(exp_mem_q.size()), 32'(exp_done_q.size() + exp_to_q.size())}, 66'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
